// File: rtl/mic_clk_ctrl.sv
// mic_clk_ctrl: enable/warm-up/stop sequencer and reloadable half-period divider for the mic clock.
// Build option MIC_EDGE_STB_EN enables rise_stb/fall_stb; when undefined both are tied low.
module mic_clk_ctrl #(
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned WARM_W      = 16,
    parameter int unsigned DEFAULT_DIV = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [WARM_W-1:0] warmup_cycles,
    output logic              mic_clk,
    output logic              rise_stb,
    output logic              fall_stb,
    output logic              running,
    output logic              busy
);

    typedef enum logic [1:0] {StIdle, StWarmup, StRun, StStop} state_e;

    localparam logic [DIV_W-1:0]  DivOne  = DIV_W'(1);
    localparam logic [DIV_W-1:0]  DivMin  = DIV_W'(2);
    localparam logic [DIV_W-1:0]  DivRst  = DIV_W'(DEFAULT_DIV);
    localparam logic [WARM_W-1:0] WarmOne = WARM_W'(1);

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DIV_W-1:0]  pend_div_q, pend_div_d;
    logic              pend_q, pend_d;
    logic [WARM_W-1:0] warm_q, warm_d;
    logic              mic_clk_q, mic_clk_d;

    logic              cfg_xfer;
    logic [DIV_W-1:0]  cfg_div_sat;
    logic              dividing;
    logic              period_end;
    logic              stop_done;
    logic              toggle;
    logic              rise;
    logic              fall;
    logic              apply_pend;

    assign cfg_ready   = !pend_q;
    assign cfg_xfer    = cfg_valid && cfg_ready;
    assign cfg_div_sat = (cfg_div < DivMin) ? DivMin : cfg_div;

    assign dividing   = (state_q != StIdle);
    assign period_end = dividing && (cnt_q == (div_q - DivOne));
    // In STOP the rise that would start a new period is suppressed, so the clock parks low.
    assign stop_done  = (state_q == StStop) && !mic_clk_q && period_end;
    assign toggle     = period_end && !stop_done;
    assign rise       = toggle && !mic_clk_q;
    assign fall       = toggle && mic_clk_q;

    // Pending value lands only on a full-period boundary, or whenever the clock is parked.
    assign apply_pend = pend_q && (rise || stop_done || (state_q == StIdle));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        pend_d     = pend_q;
        pend_div_d = pend_div_q;
        warm_d     = warm_q;
        mic_clk_d  = mic_clk_q;

        if (dividing) begin
            cnt_d = period_end ? '0 : (cnt_q + DivOne);
            if (toggle) begin
                mic_clk_d = !mic_clk_q;
            end
        end

        if (apply_pend) begin
            div_d  = pend_div_q;
            pend_d = 1'b0;
        end else if (cfg_xfer) begin
            if (state_q == StIdle) begin
                div_d = cfg_div_sat;
            end else begin
                pend_d     = 1'b1;
                pend_div_d = cfg_div_sat;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    warm_d    = warmup_cycles;
                    cnt_d     = '0;
                    mic_clk_d = 1'b0;
                    state_d   = (warmup_cycles == '0) ? StRun : StWarmup;
                end
            end
            StWarmup: begin
                if (!enable) begin
                    state_d = StStop;
                end else if (rise) begin
                    warm_d = warm_q - WarmOne;
                    if (warm_q == WarmOne) begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (!enable) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (stop_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            div_q      <= DivRst;
            pend_q     <= 1'b0;
            pend_div_q <= '0;
            warm_q     <= '0;
            mic_clk_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_q     <= pend_d;
            pend_div_q <= pend_div_d;
            warm_q     <= warm_d;
            mic_clk_q  <= mic_clk_d;
        end
    end

    assign mic_clk = mic_clk_q;
    assign running = (state_q == StRun);
    assign busy    = (state_q != StIdle);

`ifdef MIC_EDGE_STB_EN
    logic from_run_q, from_run_d;
    logic stb_allow;
    logic rise_stb_q;
    logic fall_stb_q;

    // Remembers whether STOP was entered from RUN; warm-up edges never strobe.
    assign from_run_d = (state_q == StStop) ? from_run_q : (state_q == StRun);
    assign stb_allow  = (state_q == StRun) || ((state_q == StStop) && from_run_q);

    always_ff @(posedge clk) begin
        if (!reset) begin
            from_run_q <= 1'b0;
            rise_stb_q <= 1'b0;
            fall_stb_q <= 1'b0;
        end else begin
            from_run_q <= from_run_d;
            rise_stb_q <= rise && stb_allow;
            fall_stb_q <= fall && stb_allow;
        end
    end

    assign rise_stb = rise_stb_q;
    assign fall_stb = fall_stb_q;
`else
    assign rise_stb = 1'b0;
    assign fall_stb = 1'b0;
`endif

endmodule
